// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial subtractor.
// The master drives operands and start; the slave returns status and the result.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  ready, busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output ready, busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B - bin controller: one full-subtractor step per cycle, LSB first.
// Optional SERIAL_SUB_SAT_EN clamps an underflowing result to zero (bout still set).
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             bit_diff_s;
    logic             bit_borrow_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] res_next_s;
    logic             ready_s;
    logic             busy_s;
    logic             done_s;

    function automatic logic fs_diff(input logic x, input logic y, input logic br);
        return x ^ y ^ br;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic br);
        return (~x & y) | (~(x ^ y) & br);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs
    always_comb begin
        bit_diff_s   = fs_diff(a_sh_q[0], b_sh_q[0], borrow_q);
        bit_borrow_s = fs_borrow(a_sh_q[0], b_sh_q[0], borrow_q);
        res_next_s   = {bit_diff_s, res_sh_q[WIDTH-1:1]};
        last_bit_s   = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Datapath next values; the result is published with the final bit folded in
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = {CNT_W{1'b0}};
                end else begin
                    cnt_d    = cnt_q;
                end
            end
            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = res_next_s;
                borrow_d = bit_borrow_s;
                if (last_bit_s) begin
                    cnt_d  = {CNT_W{1'b0}};
`ifdef SERIAL_SUB_SAT_EN
                    if (bit_borrow_s) begin
                        diff_d = {WIDTH{1'b0}};
                    end else begin
                        diff_d = res_next_s;
                    end
`else
                    diff_d = res_next_s;
`endif
                    bout_d = bit_borrow_s;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            res_sh_q <= {WIDTH{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    // Status decode from the registered state
    always_comb begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            ST_IDLE: ready_s = 1'b1;
            ST_RUN:  busy_s  = 1'b1;
            ST_DONE: done_s  = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    assign bus.ready = ready_s;
    assign bus.busy  = busy_s;
    assign bus.done  = done_s;
    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl: an 8-bit instance for handshake,
// corner and reset cases, and a 4-bit instance swept over every (a, b, bin).
module tb_serial_subtractor_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [7:0] last_diff8;

    serial_subtractor_ctrl_if #(.WIDTH(8)) if8 ();
    serial_subtractor_ctrl_if #(.WIDTH(4)) if4 ();

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_subtractor_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sat8(input logic [7:0] d, input logic bo);
`ifdef SERIAL_SUB_SAT_EN
        return bo ? 8'h00 : d;
`else
        return d;
`endif
    endfunction

    // One 8-bit operation with full latency/handshake checks; called at a negedge in IDLE
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] ed, input logic eb);
        int busy_cnt;
        int waited;
        busy_cnt = 0;
        waited   = 0;
        check_val({tag, "_ready"}, {31'd0, if8.ready}, 32'd1);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.bin   = bin;
        @(negedge clk);
        if8.start = 1'b0;
        if8.a     = ~a;
        if8.b     = ~b;
        check_val({tag, "_hold"}, {24'd0, if8.diff}, {24'd0, last_diff8});
        while (!if8.done && waited < 30) begin
            if (if8.busy) busy_cnt++;
            waited++;
            @(negedge clk);
        end
        check_val({tag, "_done"}, {31'd0, if8.done}, 32'd1);
        check_val({tag, "_busy_cycles"}, busy_cnt, 32'd8);
        check_val({tag, "_diff"}, {24'd0, if8.diff}, {24'd0, ed});
        check_val({tag, "_bout"}, {31'd0, if8.bout}, {31'd0, eb});
        last_diff8 = ed;
        @(negedge clk);
        check_val({tag, "_done_pulse"}, {31'd0, if8.done}, 32'd0);
        check_val({tag, "_ready_back"}, {31'd0, if8.ready}, 32'd1);
    endtask

    initial begin
        int waited;
        int busy_cnt;
        logic [3:0] av, bv;
        logic       cv;
        logic [4:0] r4;
        logic [3:0] ed4;

        n_checks   = 0;
        n_pass     = 0;
        last_diff8 = 8'h00;
        rst = 1'b1;
        if8.start = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.bin = 1'b0;
        if4.start = 1'b0; if4.a = 4'h0;  if4.b = 4'h0;  if4.bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'd0, if8.ready}, 32'd1);
        check_val("rst_busy",  {31'd0, if8.busy},  32'd0);
        check_val("rst_done",  {31'd0, if8.done},  32'd0);
        check_val("rst_diff",  {24'd0, if8.diff},  32'd0);
        check_val("rst_bout",  {31'd0, if8.bout},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        op8("basic",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        op8("uflow",   8'h00, 8'h01, 1'b0, sat8(8'hFF, 1'b1), 1'b1);
        op8("ff_ff_1", 8'hFF, 8'hFF, 1'b1, sat8(8'hFF, 1'b1), 1'b1);
        op8("a5_5a",   8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0);
        op8("5a_a5_1", 8'h5A, 8'hA5, 1'b1, sat8(8'hB4, 1'b1), 1'b1);
        op8("zero",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // start held high through RUN and DONE with different operands
        if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h01; if8.bin = 1'b0;
        @(negedge clk);
        if8.a = 8'h00; if8.b = 8'h00;
        busy_cnt = 0;
        waited   = 0;
        while (!if8.done && waited < 30) begin
            if (if8.busy) busy_cnt++;
            waited++;
            @(negedge clk);
        end
        check_val("rej_done", {31'd0, if8.done}, 32'd1);
        check_val("rej_busy_cycles", busy_cnt, 32'd8);
        check_val("rej_diff", {24'd0, if8.diff}, 32'h0F);
        check_val("rej_bout", {31'd0, if8.bout}, 32'd0);
        @(negedge clk);
        if8.start = 1'b0;
        check_val("rej_ready", {31'd0, if8.ready}, 32'd1);
        check_val("rej_single_done", {31'd0, if8.done}, 32'd0);
        @(negedge clk);
        check_val("rej_idle", {31'd0, if8.busy}, 32'd0);
        check_val("rej_hold", {24'd0, if8.diff}, 32'h0F);
        last_diff8 = 8'h0F;

        // reset in the middle of an operation
        if8.start = 1'b1; if8.a = 8'h80; if8.b = 8'h01; if8.bin = 1'b0;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("mid_busy", {31'd0, if8.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_ready", {31'd0, if8.ready}, 32'd1);
        check_val("mid_busy0", {31'd0, if8.busy},  32'd0);
        check_val("mid_diff",  {24'd0, if8.diff},  32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if8.done || if8.busy) busy_cnt++;
        end
        check_val("mid_no_done", busy_cnt, 32'd0);
        last_diff8 = 8'h00;
        op8("after_rst", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

        // every 4-bit operand combination, issued as soon as ready returns
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    av = ai[3:0];
                    bv = bi[3:0];
                    cv = ci[0];
                    r4 = {1'b0, av} - {1'b0, bv} - {4'd0, cv};
`ifdef SERIAL_SUB_SAT_EN
                    ed4 = r4[4] ? 4'h0 : r4[3:0];
`else
                    ed4 = r4[3:0];
`endif
                    waited = 0;
                    while (!if4.ready && waited < 20) begin
                        @(negedge clk);
                        waited++;
                    end
                    if4.start = 1'b1; if4.a = av; if4.b = bv; if4.bin = cv;
                    @(negedge clk);
                    if4.start = 1'b0;
                    waited = 0;
                    while (!if4.done && waited < 20) begin
                        @(negedge clk);
                        waited++;
                    end
                    check_val("x4_done", {31'd0, if4.done}, 32'd1);
                    check_val("x4_diff", {28'd0, if4.diff}, {28'd0, ed4});
                    check_val("x4_bout", {31'd0, if4.bout}, {31'd0, r4[4]});
                    @(negedge clk);
                    check_val("x4_hold", {28'd0, if4.diff}, {28'd0, ed4});
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
